boxcar_avg: RTL
===============

Name: boxcar_avg

Overview:
- Moving-average (boxcar) low-pass stage on signed fixed-point samples; sits directly upstream of the constant-offset adder stage and feeds it.
- Averages the last 2^len_log2 accepted samples; output is in the same width_H.width_W format as the input.
- Uses the same valid-strobe framing as the rest of the filter chain.

Parameters:
- width_H, 5, integer bits including sign.
- width_W, 20, fractional bits.
- len_log2, 4, log2 of the window length N (N = 16 by default); legal range 1..8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- data_i_en  in  1  input sample valid strobe.
- data_i  in  width_H+width_W  signed two's-complement sample.
- data_o_en  out  1  output valid, one-cycle pulse per accepted input.
- data_o  out  width_H+width_W  signed average.

Behaviour:
- Let DW = width_H+width_W. Accumulator width is DW+len_log2, signed, so it never overflows.
- Reset, synchronous, clears on the next clk edge with rst=1:
  - data_o=0, data_o_en=0.
  - Accumulator=0, write pointer=0, fill counter=0.
  - All pipeline valid bits=0.
  - Ring-buffer contents are not cleared; the fill counter masks them.
- rst has priority over data_i_en in the same cycle; that sample is dropped.
- Ring buffer: N entries × DW, circular write pointer, read-before-write at the same address in the same cycle (returns the old value).
- Pipeline, 3 cycles latency from data_i_en edge to data_o_en:
  - S1, on data_i_en=1: read oldest=buf[wr_ptr]; write buf[wr_ptr]=data_i; wr_ptr++ (wraps N-1→0).
    - Register new=data_i.
    - Register old=(fill==N) ? oldest : 0.
    - fill increments, saturating at N.
    - v1=1.
  - S2: if v1, acc <= acc + sext(new) - sext(old); v2=v1.
  - S3: if v2, data_o <= (acc + 2^(len_log2-1)) >>> len_log2, truncated to DW (round half up); data_o_en=v2.
- Rounding never overflows: |result| ≤ max input magnitude, so no saturation logic.
- data_o holds its last value while data_o_en=0; data_o_en is a strict pulse, never held.
- Throughput: one sample per cycle, back-to-back, with no stalls and no backpressure (downstream is always ready).
- Gaps in data_i_en freeze the pipeline contents and do not affect results: the sparse sequence gives identical values to the dense one.
- Warm-up: for the first N-1 outputs, missing samples count as 0. The divisor is always N, not the fill count.
- Reset mid-operation flushes in-flight samples; no output pulse follows for them.

Decomposition:
- Package filt_pkg:
  - Function sample_w(width_H,width_W).
  - Function acc_w(DW,len_log2).
  - typedef for signed sample type.
  - Shared across filter stages.
- Sub-module boxcar_ring_buf:
  - Ports: clk, we, addr, wdata, rdata.
  - Synchronous read-first RAM of N×DW, inferable as block/distributed RAM, with no reset.
  - The pointer and fill logic stay in boxcar_avg.

Test Plan (defaults: DW=25, N=16):
- Reset: assert rst 2 cycles mid-stream → next cycle data_o=0, data_o_en=0; no stray pulses for in-flight samples.
- Impulse: data_i=16 for one strobe, then zeros on every cycle → data_o=1 for exactly 16 pulses, then 0. The first pulse comes 3 cycles after the impulse strobe.
- Step: constant 2^20 (1.0) every cycle → outputs k·2^16 for k=1..16, then steady 2^20.
- Negative full scale: constant -2^24 for 20 strobes → final outputs exactly -2^24; no wrap.
- Rounding: single sample 8 then zeros → 1 ×16. Single sample -8 then zeros → 0 ×16 (half rounds up).
- Sparse vs dense: the same 40-sample random sequence with random gaps in data_i_en, and a rst after sample 5 followed by a restart → output values match the golden model; the ramp restarts from 1/16 of the input.

Source files
------------

// File: rtl/filt_pkg.sv
// rtl/filt_pkg.sv - shared fixed-point sizing helpers and sample type for the filter chain
package filt_pkg;

    localparam int DEF_WIDTH_H  = 5;
    localparam int DEF_WIDTH_W  = 20;
    localparam int DEF_LEN_LOG2 = 4;

    function automatic int sample_w(input int width_h, input int width_w);
        return width_h + width_w;
    endfunction

    // Room for the sum of 2^len_log2 full-scale samples without overflow.
    function automatic int acc_w(input int dw, input int len_log2);
        return dw + len_log2;
    endfunction

    localparam int DEF_SAMPLE_W = sample_w(DEF_WIDTH_H, DEF_WIDTH_W);

    typedef logic signed [DEF_SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/boxcar_ring_buf.sv
// rtl/boxcar_ring_buf.sv - synchronous read-first sample RAM, no reset
module boxcar_ring_buf #(
    parameter int DW         = 25,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DW-1:0]         wdata,
    output logic [DW-1:0]         rdata
);

    logic [DW-1:0] mem_q [2**DEPTH_LOG2];

    // Read and write share the address; the read returns the value being overwritten.
    always_ff @(posedge clk) begin
        rdata <= mem_q[addr];
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/boxcar_avg.sv
// rtl/boxcar_avg.sv - moving-average of the last 2^len_log2 samples, 3-cycle pipeline
module boxcar_avg
    import filt_pkg::*;
#(
    parameter int width_H  = DEF_WIDTH_H,
    parameter int width_W  = DEF_WIDTH_W,
    parameter int len_log2 = DEF_LEN_LOG2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          data_i_en,
    input  logic signed [sample_w(width_H, width_W)-1:0]  data_i,
    output logic                                          data_o_en,
    output logic signed [sample_w(width_H, width_W)-1:0]  data_o
);

    localparam int DW = sample_w(width_H, width_W);
    localparam int AW = acc_w(DW, len_log2);

    localparam logic [len_log2:0]      FILL_FULL = {1'b1, {len_log2{1'b0}}};
    localparam logic [len_log2-1:0]    PTR_ONE   = len_log2'(1);
    localparam logic signed [AW-1:0]   HALF      = AW'(1) <<< (len_log2 - 1);

    // Stage 1 state
    logic [len_log2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [len_log2:0]    fill_q, fill_d;
    logic signed [DW-1:0] new_q, new_d;
    logic                 old_sel_q, old_sel_d;
    logic                 v1_q, v1_d;

    // Stage 2 state
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 v2_q, v2_d;

    // Stage 3 state
    logic signed [DW-1:0] data_o_q, data_o_d;
    logic                 data_o_en_q, data_o_en_d;

    logic [DW-1:0]        ram_rdata;
    logic                 ram_we;
    logic signed [AW-1:0] new_ext;
    logic signed [AW-1:0] old_ext;

    assign ram_we = data_i_en & ~rst;

    boxcar_ring_buf #(
        .DW         (DW),
        .DEPTH_LOG2 (len_log2)
    ) u_ring_buf (
        .clk   (clk),
        .we    (ram_we),
        .addr  (wr_ptr_q),
        .wdata (data_i),
        .rdata (ram_rdata)
    );

    // The RAM output register doubles as the stage-1 "oldest" register; old_sel_q
    // records whether that slot held a real sample when it was read.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        fill_d    = fill_q;
        new_d     = new_q;
        old_sel_d = old_sel_q;
        v1_d      = 1'b0;
        if (data_i_en) begin
            wr_ptr_d  = wr_ptr_q + PTR_ONE;
            fill_d    = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
            new_d     = data_i;
            old_sel_d = (fill_q == FILL_FULL);
            v1_d      = 1'b1;
        end
    end

    always_comb begin
        new_ext = {{len_log2{new_q[DW-1]}}, new_q};
        old_ext = '0;
        if (old_sel_q) begin
            old_ext = {{len_log2{ram_rdata[DW-1]}}, ram_rdata};
        end
        acc_d = acc_q;
        if (v1_q) begin
            acc_d = acc_q + new_ext - old_ext;
        end
        v2_d = v1_q;
    end

    // Round half up; the result always fits back into DW bits.
    always_comb begin
        data_o_d = data_o_q;
        if (v2_q) begin
            data_o_d = DW'((acc_q + HALF) >>> len_log2);
        end
        data_o_en_d = v2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            new_q       <= '0;
            old_sel_q   <= 1'b0;
            v1_q        <= 1'b0;
            acc_q       <= '0;
            v2_q        <= 1'b0;
            data_o_q    <= '0;
            data_o_en_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            new_q       <= new_d;
            old_sel_q   <= old_sel_d;
            v1_q        <= v1_d;
            acc_q       <= acc_d;
            v2_q        <= v2_d;
            data_o_q    <= data_o_d;
            data_o_en_q <= data_o_en_d;
        end
    end

    assign data_o    = data_o_q;
    assign data_o_en = data_o_en_q;

endmodule
